// File: rtl/uart_loop_fifo.sv
// UART echo: synchronised RX engine -> circular FIFO -> TX engine, with sticky error flags.
// Define UART_PARITY_EN to add a parity bit (even/odd via PARITY_ODD) on both RX and TX.
module uart_loop_fifo #(
  parameter int CLK_FREQ   = 50000000,
  parameter int UART_BPS   = 115200,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16,
  parameter int PARITY_ODD = 0
) (
  input  logic                          sys_clk,
  input  logic                          sys_rst,
  input  logic                          uart_rxd,
  output logic                          uart_txd,
  input  logic                          tx_pause,
  input  logic                          clear_err,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow_err,
  output logic                          frame_err,
  output logic                          parity_err
);

  localparam int BAUD_DIV = CLK_FREQ / UART_BPS;
  localparam int AW       = $clog2(FIFO_DEPTH);
  localparam int LVL_W    = AW + 1;
  localparam int CNT_W    = $clog2(STOP_BITS * BAUD_DIV + 1);
  localparam int IDX_W    = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BAUD_DIV / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_BITS * BAUD_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);
  localparam logic [LVL_W-1:0] FULL_LVL  = LVL_W'(FIFO_DEPTH);
`ifdef UART_PARITY_EN
  localparam logic PAR_ODD = 1'(PARITY_ODD);
`endif

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  logic r_rxMeta, r_rxSync, r_rxPrev;
  logic w_rxFall;

  state_t               r_rxState, w_rxStateNext;
  logic [CNT_W-1:0]     r_rxCnt, w_rxCntNext;
  logic [IDX_W-1:0]     r_rxIdx, w_rxIdxNext;
  logic [DATA_BITS-1:0] r_rxShift, w_rxShiftNext;
  logic                 w_rxDone, w_rxParOk, w_rxPush;
  logic                 w_frameEvt, w_parityEvt, w_overflowEvt;
`ifdef UART_PARITY_EN
  logic                 r_rxParBit, w_rxParBitNext;
`endif

  logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]        r_wrPtr, r_rdPtr;
  logic [LVL_W-1:0]     r_level;
  logic                 w_full, w_pushOk;

  state_t               r_txState, w_txStateNext;
  logic [CNT_W-1:0]     r_txCnt, w_txCntNext;
  logic [IDX_W-1:0]     r_txIdx, w_txIdxNext;
  logic [DATA_BITS-1:0] r_txShift, w_txShiftNext;
  logic [DATA_BITS-1:0] w_txHead;
  logic                 r_txd, w_txdNext;
  logic                 w_txPop, w_txCanStart;
`ifdef UART_PARITY_EN
  logic                 r_txPar, w_txParNext;
`endif

  logic r_overflowErr, r_frameErr;

  // rxd is asynchronous; r_rxPrev keeps one more stage for falling-edge detection
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      {r_rxMeta, r_rxSync, r_rxPrev} <= 3'b111;
    end else begin
      {r_rxMeta, r_rxSync, r_rxPrev} <= {uart_rxd, r_rxMeta, r_rxSync};
    end
  end

  assign w_rxFall = r_rxPrev & ~r_rxSync;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_rxState  <= IDLE;
      r_rxCnt    <= '0;
      r_rxIdx    <= '0;
      r_rxShift  <= '0;
`ifdef UART_PARITY_EN
      r_rxParBit <= 1'b0;
`endif
    end else begin
      r_rxState  <= w_rxStateNext;
      r_rxCnt    <= w_rxCntNext;
      r_rxIdx    <= w_rxIdxNext;
      r_rxShift  <= w_rxShiftNext;
`ifdef UART_PARITY_EN
      r_rxParBit <= w_rxParBitNext;
`endif
    end
  end

  // START re-checks the line at half a bit; later samples land on bit centres
  always_comb begin
    w_rxStateNext  = r_rxState;
    w_rxCntNext    = r_rxCnt + 1'b1;
    w_rxIdxNext    = r_rxIdx;
    w_rxShiftNext  = r_rxShift;
    w_rxDone       = 1'b0;
`ifdef UART_PARITY_EN
    w_rxParBitNext = r_rxParBit;
`endif
    case (r_rxState)
      IDLE: begin
        w_rxCntNext = '0;
        if (w_rxFall) w_rxStateNext = START;
      end
      START: begin
        if (r_rxCnt == HALF_LAST) begin
          w_rxCntNext   = '0;
          w_rxIdxNext   = '0;
          w_rxStateNext = r_rxSync ? IDLE : DATA;
        end
      end
      DATA: begin
        if (r_rxCnt == BIT_LAST) begin
          w_rxCntNext   = '0;
          w_rxShiftNext = {r_rxSync, r_rxShift[DATA_BITS-1:1]};
          if (r_rxIdx == IDX_LAST) begin
`ifdef UART_PARITY_EN
            w_rxStateNext = PAR;
`else
            w_rxStateNext = STOP;
`endif
          end else begin
            w_rxIdxNext = r_rxIdx + 1'b1;
          end
        end
      end
`ifdef UART_PARITY_EN
      PAR: begin
        if (r_rxCnt == BIT_LAST) begin
          w_rxCntNext    = '0;
          w_rxParBitNext = r_rxSync;
          w_rxStateNext  = STOP;
        end
      end
`endif
      STOP: begin
        if (r_rxCnt == BIT_LAST) begin
          w_rxCntNext   = '0;
          w_rxDone      = 1'b1;
          w_rxStateNext = IDLE;
        end
      end
      default: w_rxStateNext = IDLE;
    endcase
  end

`ifdef UART_PARITY_EN
  assign w_rxParOk   = ((^r_rxShift) ^ r_rxParBit) == PAR_ODD;
`else
  assign w_rxParOk   = 1'b1;
`endif
  // A bad stop bit takes precedence over a parity mismatch
  assign w_frameEvt    = w_rxDone & ~r_rxSync;
  assign w_parityEvt   = w_rxDone & r_rxSync & ~w_rxParOk;
  assign w_rxPush      = w_rxDone & r_rxSync & w_rxParOk;

  assign w_full        = (r_level == FULL_LVL);
  assign w_pushOk      = w_rxPush & (~w_full | w_txPop);
  assign w_overflowEvt = w_rxPush & w_full & ~w_txPop;
  assign w_txHead      = r_mem[r_rdPtr];
  assign w_txCanStart  = (r_level != '0) & ~tx_pause;

  always_ff @(posedge sys_clk) begin
    if (w_pushOk) r_mem[r_wrPtr] <= r_rxShift;
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_level <= '0;
    end else begin
      if (w_pushOk) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_txPop)  r_rdPtr <= r_rdPtr + 1'b1;
      case ({w_pushOk, w_txPop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_txState <= IDLE;
      r_txCnt   <= '0;
      r_txIdx   <= '0;
      r_txShift <= '0;
      r_txd     <= 1'b1;
`ifdef UART_PARITY_EN
      r_txPar   <= 1'b0;
`endif
    end else begin
      r_txState <= w_txStateNext;
      r_txCnt   <= w_txCntNext;
      r_txIdx   <= w_txIdxNext;
      r_txShift <= w_txShiftNext;
      r_txd     <= w_txdNext;
`ifdef UART_PARITY_EN
      r_txPar   <= w_txParNext;
`endif
    end
  end

  // txd is registered from the next state, so the line changes the cycle after a pop
  always_comb begin
    w_txStateNext = r_txState;
    w_txCntNext   = r_txCnt + 1'b1;
    w_txIdxNext   = r_txIdx;
    w_txShiftNext = r_txShift;
    w_txPop       = 1'b0;
`ifdef UART_PARITY_EN
    w_txParNext   = r_txPar;
`endif
    case (r_txState)
      IDLE: begin
        w_txCntNext = '0;
        if (w_txCanStart) begin
          w_txPop       = 1'b1;
          w_txShiftNext = w_txHead;
          w_txStateNext = START;
`ifdef UART_PARITY_EN
          w_txParNext   = (^w_txHead) ^ PAR_ODD;
`endif
        end
      end
      START: begin
        if (r_txCnt == BIT_LAST) begin
          w_txCntNext   = '0;
          w_txIdxNext   = '0;
          w_txStateNext = DATA;
        end
      end
      DATA: begin
        if (r_txCnt == BIT_LAST) begin
          w_txCntNext = '0;
          if (r_txIdx == IDX_LAST) begin
`ifdef UART_PARITY_EN
            w_txStateNext = PAR;
`else
            w_txStateNext = STOP;
`endif
          end else begin
            w_txIdxNext   = r_txIdx + 1'b1;
            w_txShiftNext = r_txShift >> 1;
          end
        end
      end
`ifdef UART_PARITY_EN
      PAR: begin
        if (r_txCnt == BIT_LAST) begin
          w_txCntNext   = '0;
          w_txStateNext = STOP;
        end
      end
`endif
      STOP: begin
        if (r_txCnt == STOP_LAST) begin
          w_txCntNext   = '0;
          w_txStateNext = IDLE;
          if (w_txCanStart) begin
            w_txPop       = 1'b1;
            w_txShiftNext = w_txHead;
            w_txStateNext = START;
`ifdef UART_PARITY_EN
            w_txParNext   = (^w_txHead) ^ PAR_ODD;
`endif
          end
        end
      end
      default: w_txStateNext = IDLE;
    endcase

    case (w_txStateNext)
      START:   w_txdNext = 1'b0;
      DATA:    w_txdNext = w_txShiftNext[0];
`ifdef UART_PARITY_EN
      PAR:     w_txdNext = w_txParNext;
`endif
      default: w_txdNext = 1'b1;
    endcase
  end

  // A new error in the same cycle as clear_err wins
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_overflowErr <= 1'b0;
      r_frameErr    <= 1'b0;
    end else begin
      if (w_overflowEvt)  r_overflowErr <= 1'b1;
      else if (clear_err) r_overflowErr <= 1'b0;
      if (w_frameEvt)     r_frameErr    <= 1'b1;
      else if (clear_err) r_frameErr    <= 1'b0;
    end
  end

`ifdef UART_PARITY_EN
  logic r_parityErr;
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst)          r_parityErr <= 1'b0;
    else if (w_parityEvt) r_parityErr <= 1'b1;
    else if (clear_err)   r_parityErr <= 1'b0;
  end
  assign parity_err = r_parityErr;
`else
  assign parity_err = 1'b0;
`endif

  assign uart_txd     = r_txd;
  assign fifo_level   = r_level;
  assign overflow_err = r_overflowErr;
  assign frame_err    = r_frameErr;

endmodule

// File: tb/tb_uart_loop_fifo.sv
// Scoreboard bench for uart_loop_fifo: RX stimulus queues expected echoes, a TX monitor decodes and compares.
`timescale 1ns/1ps
module tb_uart_loop_fifo;

  localparam int CLK_FREQ   = 1600000;
  localparam int UART_BPS   = 100000;
  localparam int BD         = CLK_FREQ / UART_BPS;
  localparam int DATA_BITS  = 8;
  localparam int FIFO_DEPTH = 4;
  localparam int PARITY_ODD = 0;
`ifdef UART_PARITY_EN
  localparam int PAR_BITS   = 1;
`else
  localparam int PAR_BITS   = 0;
`endif
  localparam int STOP_IDX   = 1 + DATA_BITS + PAR_BITS;

  logic       sys_clk   = 1'b0;
  logic       sys_rst   = 1'b1;
  logic       uart_rxd  = 1'b1;
  logic       tx_pause  = 1'b0;
  logic       clear_err = 1'b0;
  logic       uart_txd;
  logic [2:0] fifo_level;
  logic       overflow_err, frame_err, parity_err;

  int         errors = 0;
  int         checks = 0;
  logic [7:0] expQ[$];
  bit         monBusy = 1'b0;

  uart_loop_fifo #(
    .CLK_FREQ  (CLK_FREQ),
    .UART_BPS  (UART_BPS),
    .DATA_BITS (DATA_BITS),
    .STOP_BITS (1),
    .FIFO_DEPTH(FIFO_DEPTH),
    .PARITY_ODD(PARITY_ODD)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .uart_rxd    (uart_rxd),
    .uart_txd    (uart_txd),
    .tx_pause    (tx_pause),
    .clear_err   (clear_err),
    .fifo_level  (fifo_level),
    .overflow_err(overflow_err),
    .frame_err   (frame_err),
    .parity_err  (parity_err)
  );

  always #10 sys_clk = ~sys_clk;

  function automatic logic parOf(input logic [7:0] d);
    return (^d) ^ 1'(PARITY_ODD);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // Drives one RX frame from a negedge; queues the byte when an echo is expected
  task automatic applyStimulus(input logic [7:0] data, input logic stopBit, input logic parBit, input bit expectEcho);
    if (expectEcho) expQ.push_back(data);
    uart_rxd = 1'b0;
    repeat (BD) @(negedge sys_clk);
    for (int i = 0; i < DATA_BITS; i++) begin
      uart_rxd = data[i];
      repeat (BD) @(negedge sys_clk);
    end
`ifdef UART_PARITY_EN
    uart_rxd = parBit;
    repeat (BD) @(negedge sys_clk);
`endif
    uart_rxd = stopBit;
    repeat (BD) @(negedge sys_clk);
    uart_rxd = 1'b1;
  endtask

  task automatic waitDrain(input int maxCycles);
    int n;
    n = 0;
    while ((expQ.size() != 0 || monBusy) && n < maxCycles) begin
      @(negedge sys_clk);
      n++;
    end
    checkOutput("echo_drain_pending", expQ.size(), 0);
  endtask

  task automatic pulseClear();
    clear_err = 1'b1;
    @(negedge sys_clk);
    clear_err = 1'b0;
    @(negedge sys_clk);
  endtask

  initial begin : monitor
    int         cnt, pos, k;
    logic [7:0] sh;
    logic [7:0] expByte;
    logic       pb;
    cnt = 0; sh = '0; pb = 1'b0; expByte = '0;
    forever begin
      @(negedge sys_clk);
      if (sys_rst) begin
        monBusy = 1'b0;
      end else if (!monBusy) begin
        if (uart_txd === 1'b0) begin
          monBusy = 1'b1;
          cnt = 0;
        end
      end else begin
        cnt++;
        pos = cnt - BD / 2;
        if (pos >= 0 && (pos % BD) == 0) begin
          k = pos / BD;
          if (k == 0) begin
            checkOutput("tx_start_bit", uart_txd, 0);
          end else if (k <= DATA_BITS) begin
            sh[k-1] = uart_txd;
          end else if (k < STOP_IDX) begin
            pb = uart_txd;
          end else begin
            checkOutput("tx_stop_bit", uart_txd, 1);
            if (expQ.size() == 0) begin
              checks++;
              errors++;
              $display("[TB] FAIL tx_unexpected_frame: got 0x%0h expected no frame", sh);
            end else begin
              expByte = expQ.pop_front();
              checkOutput("tx_echo_data", sh, expByte);
`ifdef UART_PARITY_EN
              checkOutput("tx_parity_bit", pb, parOf(expByte));
`endif
            end
            monBusy = 1'b0;
          end
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] timeout");
  end

  initial begin : stim
    int lowCnt, n, seen;
    lowCnt = 0; n = 0; seen = 0;

    repeat (3) @(negedge sys_clk);
    checkOutput("reset_txd", uart_txd, 1);
    checkOutput("reset_level", fifo_level, 0);
    checkOutput("reset_overflow", overflow_err, 0);
    checkOutput("reset_frame", frame_err, 0);
    checkOutput("reset_parity", parity_err, 0);
    sys_rst = 1'b0;
    repeat (5) @(negedge sys_clk);

    $display("[TB] single byte echo 0x55");
    fork
      applyStimulus(8'h55, 1'b1, parOf(8'h55), 1'b1);
      begin
        n = 0;
        while (fifo_level !== 3'd1 && n < 20 * BD) begin
          @(negedge sys_clk);
          n++;
        end
        checkOutput("t1_level_pulse", fifo_level, 1);
        @(negedge sys_clk);
        checkOutput("t1_level_after_pop", fifo_level, 0);
        checkOutput("t1_txd_start_latency", uart_txd, 0);
        lowCnt = 0;
        while (uart_txd === 1'b0 && lowCnt < 4 * BD) begin
          lowCnt++;
          @(negedge sys_clk);
        end
        checkOutput("t1_start_width", lowCnt, BD);
      end
    join
    waitDrain(20 * BD);
    checkOutput("t1_frame_err", frame_err, 0);
    checkOutput("t1_overflow_err", overflow_err, 0);
    checkOutput("t1_parity_err", parity_err, 0);

    $display("[TB] bad stop bit 0xA3");
    applyStimulus(8'hA3, 1'b0, parOf(8'hA3), 1'b0);
    repeat (BD) @(negedge sys_clk);
    checkOutput("t3_frame_err_set", frame_err, 1);
    checkOutput("t3_level", fifo_level, 0);
    checkOutput("t3_txd_idle", uart_txd, 1);
    pulseClear();
    checkOutput("t3_frame_err_clear", frame_err, 0);

    $display("[TB] short rx glitch");
    uart_rxd = 1'b0;
    repeat (BD / 4) @(negedge sys_clk);
    uart_rxd = 1'b1;
    seen = 0;
    repeat (12 * BD) begin
      @(negedge sys_clk);
      if (fifo_level != 3'd0 || uart_txd != 1'b1) seen++;
    end
    checkOutput("t5_no_push_no_tx", seen, 0);
    checkOutput("t5_frame_err", frame_err, 0);
    checkOutput("t5_overflow_err", overflow_err, 0);

    $display("[TB] overflow with tx paused");
    tx_pause = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      applyStimulus(8'(i), 1'b1, parOf(8'(i)), i <= FIFO_DEPTH);
    end
    repeat (4) @(negedge sys_clk);
    checkOutput("t2_level_full", fifo_level, 4);
    checkOutput("t2_overflow_set", overflow_err, 1);
    checkOutput("t2_txd_paused", uart_txd, 1);
    tx_pause = 1'b0;
    waitDrain(6 * 12 * BD);
    checkOutput("t2_level_empty", fifo_level, 0);
    pulseClear();
    checkOutput("t2_overflow_clear", overflow_err, 0);

`ifdef UART_PARITY_EN
    $display("[TB] parity check 0x07");
    applyStimulus(8'h07, 1'b1, 1'b0, 1'b0);
    repeat (BD) @(negedge sys_clk);
    checkOutput("t4_parity_err_set", parity_err, 1);
    checkOutput("t4_level", fifo_level, 0);
    pulseClear();
    checkOutput("t4_parity_err_clear", parity_err, 0);
    applyStimulus(8'h07, 1'b1, 1'b1, 1'b1);
    waitDrain(20 * BD);
    checkOutput("t4_parity_err_good", parity_err, 0);
`endif

    $display("[TB] reset during tx data bit");
    tx_pause = 1'b1;
    applyStimulus(8'h3C, 1'b1, parOf(8'h3C), 1'b1);
    applyStimulus(8'h81, 1'b1, parOf(8'h81), 1'b1);
    repeat (4) @(negedge sys_clk);
    checkOutput("t6_level_before", fifo_level, 2);
    tx_pause = 1'b0;
    n = 0;
    while (uart_txd !== 1'b0 && n < 4 * BD) begin
      @(negedge sys_clk);
      n++;
    end
    repeat (BD + BD / 2) @(negedge sys_clk);
    checkOutput("t6_mid_data_bit", uart_txd, 0);
    sys_rst = 1'b1;
    #1;
    checkOutput("t6_txd_forced_high", uart_txd, 1);
    checkOutput("t6_level_cleared", fifo_level, 0);
    expQ.delete();
    repeat (3) @(negedge sys_clk);
    sys_rst = 1'b0;
    repeat (5) @(negedge sys_clk);
    checkOutput("t6_txd_after_reset", uart_txd, 1);
    applyStimulus(8'hC4, 1'b1, parOf(8'hC4), 1'b1);
    waitDrain(20 * BD);

    repeat (2 * BD) @(negedge sys_clk);
    checkOutput("final_queue_empty", expQ.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_loop_fifo.md
Name: uart_loop_fifo

Overview:
Parametrised successor to the team's fixed 8N1 UART echo top. It integrates its own RX and TX engines around a circular FIFO, so received characters are buffered and re-sent in order rather than passed straight through. Data width, FIFO depth, stop bits, optional parity, TX pause and sticky error flags are added. It sits at board top level between the UART pins and debug logic.

Parameters:
CLK_FREQ, 50000000, system clock frequency in Hz
UART_BPS, 115200, baud rate; BAUD_DIV = floor(CLK_FREQ/UART_BPS), must be >= 16
DATA_BITS, 8, data bits per frame, legal range 5..9
STOP_BITS, 1, TX stop bits (1 or 2); RX always checks only the first stop bit
FIFO_DEPTH, 16, number of FIFO entries; power of 2, >= 2
PARITY_ODD, 0, 0 = even parity, 1 = odd parity; used only with UART_PARITY_EN

Ports:
sys_clk  in  1  system clock, single clock domain
sys_rst  in  1  asynchronous, active-high reset
uart_rxd  in  1  serial input, asynchronous, idle high
uart_txd  out  1  serial output, idle high
tx_pause  in  1  when 1, no new TX frame starts; a frame already in progress completes
clear_err  in  1  one-cycle pulse that clears all sticky flags
fifo_level  out  $clog2(FIFO_DEPTH)+1  current number of stored entries
overflow_err  out  1  sticky; a good frame was dropped because the FIFO was full
frame_err  out  1  sticky; a stop bit was sampled low
parity_err  out  1  sticky; parity mismatch (tied 0 without UART_PARITY_EN)

Behaviour:
- Reset (asynchronous, takes effect immediately): uart_txd=1, fifo_level=0, all error flags=0, RX and TX in IDLE, FIFO pointers=0.
- uart_rxd passes through a 2-flop synchroniser. All RX decisions use the synchronised value.
- RX FSM states: IDLE, START, DATA, PAR, STOP.
  - IDLE->START on a synchronised high-to-low edge.
  - In START, the line is re-checked at BAUD_DIV/2. If it is high, the event is treated as a glitch and the FSM returns to IDLE.
  - DATA samples DATA_BITS bits, LSB first, at each subsequent BAUD_DIV interval (bit centre).
  - PAR is present only with the macro.
  - STOP is sampled at its bit centre, after which the FSM returns to IDLE immediately. This allows back-to-back frames.
- RX outcomes at the stop-bit centre:
  - Stop bit = 0: set frame_err, discard the byte.
  - Parity bad: set parity_err, discard the byte.
  - Otherwise: push the byte into the FIFO.
- Push and pop rules:
  - A push is accepted if the FIFO is not full, or if a pop occurs in the same cycle.
  - When full with no pop, the byte is dropped, overflow_err is set, and FIFO contents are unchanged.
  - Simultaneous push and pop: fifo_level is unchanged and both pointers advance.
  - Pointers wrap modulo FIFO_DEPTH. fifo_level distinguishes full from empty.
- TX FSM states: IDLE, START, DATA, PAR, STOP.
  - In IDLE, when fifo_level!=0 and tx_pause=0, the FSM pops the head entry in that cycle and enters START.
  - uart_txd goes low on the next cycle.
  - Each bit is held exactly BAUD_DIV cycles. Data is sent LSB first.
  - STOP holds uart_txd=1 for STOP_BITS*BAUD_DIV cycles, then the FSM returns to IDLE. A new pop may occur in that same cycle.
  - A tx_pause assertion mid-frame has no effect until the frame reaches IDLE.
- Latency: a push in cycle N gives fifo_level=1 at N+1. With the FSM idle and unpaused, the pop occurs at N+1 and uart_txd falls at N+2.
- Error flags: set on the error event and cleared by clear_err. If clear_err and a new error occur in the same cycle, the flag is set.
- Reset mid-frame: the partial RX byte is lost, a TX frame is truncated with the line forced high, and the FIFO is emptied.

Optional Feature:
UART_PARITY_EN
- Defined:
  - One parity bit follows the data bits on both RX and TX. Even or odd parity is selected by PARITY_ODD.
  - RX checks the parity bit and flags a mismatch on parity_err.
  - Frame length is 1+DATA_BITS+1+stop bits.
- Undefined:
  - No parity bit is sent or expected.
  - parity_err is constant 0.
  - Frame length is 1+DATA_BITS+stop bits.

Test Plan:
1. Default params (BAUD_DIV=434): send 0x55 on rxd -> fifo_level pulses to 1 and uart_txd sends the frame 0,1,0,1,0,1,0,1,0,1 (start, 0x55 LSB first, stop), each bit 434 cycles, with no error flags.
2. FIFO_DEPTH=4, tx_pause=1: send 0x01..0x06 -> fifo_level=4, overflow_err=1. Release tx_pause -> TX echoes 0x01,0x02,0x03,0x04 in order and fifo_level ends at 0.
3. Send 0xA3 with stop bit forced low -> frame_err=1, fifo_level stays 0, txd stays high. Pulse clear_err -> frame_err=0.
4. With UART_PARITY_EN and PARITY_ODD=0: send 0x07 with parity bit 0 -> parity_err=1, byte dropped. Send 0x07 with parity bit 1 -> echoed with parity bit 1.
5. 200-cycle low glitch on rxd -> no FIFO push, no error flags set.
6. Assert sys_rst mid TX data bit -> uart_txd=1 combinationally, fifo_level=0. After release, a new byte 0xC4 echoes correctly.
